// File: rtl/pp_accumulator_64x32.sv
// Sequential shift-and-add reducer for the 64x32 partial-product array: one partial
// product per beat, 96-bit unsigned product out over a valid/ready handshake.
module pp_accumulator_64x32 #(
  parameter int unsigned Width   = 64,
  parameter int unsigned PpCount = 32,
  parameter int unsigned IdxW    = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     pp_valid_i,
  output logic                     pp_ready_o,
  input  logic [Width-1:0]         pp_data_i,
  output logic [IdxW-1:0]          pp_idx_o,
  output logic                     prod_valid_o,
  input  logic                     prod_ready_i,
  output logic [Width+PpCount-1:0] prod_data_o,
  output logic                     busy_o
);

  localparam int unsigned ProdW = Width + PpCount;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [ProdW-1:0] acc_q, acc_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  logic             pp_accept;
  logic             prod_consume;
  logic [ProdW-1:0] pp_ext;
  logic [ProdW-1:0] pp_shifted;
  logic             idx_last;

  assign pp_accept    = pp_valid_i & pp_ready_o;
  assign prod_consume = prod_valid_o & prod_ready_i;
  assign pp_ext       = {{PpCount{1'b0}}, pp_data_i};
  assign pp_shifted   = pp_ext << idx_q;
  assign idx_last     = (idx_q == IdxW'(PpCount - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        // First beat replaces the previous product rather than adding to it.
        if (pp_accept) begin
          acc_d   = pp_ext;
          idx_d   = IdxW'(1);
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (pp_accept) begin
          acc_d = acc_q + pp_shifted;
          if (idx_last) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        if (prod_consume) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pp_ready_o   = 1'b0;
    prod_valid_o = 1'b0;
    busy_o       = 1'b0;
    unique case (state_q)
      StIdle:  pp_ready_o = ~reset_i;
      StAccum: begin
        pp_ready_o = ~reset_i;
        busy_o     = 1'b1;
      end
      StDone: begin
        prod_valid_o = 1'b1;
        busy_o       = 1'b1;
      end
      default: ;
    endcase
  end

  assign pp_idx_o    = idx_q;
  assign prod_data_o = acc_q;

endmodule

// File: doc/pp_accumulator_64x32.md
Name: pp_accumulator_64x32

Overview:
Sequential reducer that sits directly downstream of the 64x32 partial-product AND array in the multiplier datapath. It consumes the 32 partial products one per beat over a valid/ready stream, with beat i carrying in1 & {64{in2[i]}}. It shifts each partial product by its index and accumulates it into a 96-bit unsigned product. It then presents the product on an output valid/ready handshake to the writeback stage.

Parameters:
WIDTH, 64, partial-product width (multiplicand width)
PP_COUNT, 32, number of partial products per multiply (multiplier width)
IDX_W, 5, width of beat index; must equal clog2(PP_COUNT)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
pp_valid  input  1  partial product on pp_data is valid this cycle
pp_ready  output  1  block accepts a partial product this cycle
pp_data  input  WIDTH  current partial product, unshifted
pp_idx  output  IDX_W  index of the next partial product expected (0..PP_COUNT-1)
prod_valid  output  1  product on prod_data is valid
prod_ready  input  1  downstream accepts the product
prod_data  output  WIDTH+PP_COUNT  accumulated unsigned product
busy  output  1  a multiply is in progress or a product is pending

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: pp_ready=0 during the reset cycle, then 1; prod_valid=0, prod_data=0, pp_idx=0, busy=0, state=IDLE, accumulator=0.
- A beat is accepted when pp_valid && pp_ready are both high at a clock edge. A product is consumed when prod_valid && prod_ready are both high at a clock edge.
- States:
  - IDLE: pp_ready=1, busy=0. An accepted beat loads acc = zero-extended pp_data, sets pp_idx=1 and moves to ACCUM.
  - ACCUM: pp_ready=1, busy=1. An accepted beat sets acc = acc + (pp_data << pp_idx), in full WIDTH+PP_COUNT width with no truncation, and increments pp_idx. If the accepted beat has pp_idx==PP_COUNT-1, pp_idx wraps to 0 and the state moves to DONE.
  - DONE: pp_ready=0, prod_valid=1, busy=1. prod_data equals acc and stays stable while prod_valid=1. On consume, the state moves to IDLE and prod_valid drops the next cycle.
- Handshake and timing:
  - Cycles with pp_valid=0 (bubbles) leave all state unchanged.
  - Latency: prod_valid rises on the cycle after the 32nd beat is accepted. With no bubbles that is 33 cycles from the first beat to prod_valid.
  - Throughput: at most one multiply per PP_COUNT+1 cycles. DONE→IDLE costs one cycle, and pp_ready is 0 in DONE, so there is no overlap of the next multiply with a pending product.
- Arithmetic: unsigned only. The maximum sum, (2^64-1)(2^32-1), fits in 96 bits, so overflow is impossible by construction.
- Boundary conditions:
  - pp_valid asserted in DONE: ignored, no accept.
  - prod_ready asserted outside DONE: ignored.
  - Reset mid-operation (ACCUM or DONE): the partial accumulation is discarded, all outputs return to reset values, and the next accepted beat is treated as index 0.
  - Reset has priority over any simultaneous accept or consume.
  - prod_ready held high in DONE: consumed in the same cycle prod_valid is first seen, so prod_valid is high for exactly one cycle.

Test Plan:
- in1=64'hFFFF_FFFF_FFFF_FFFF, in2=32'hFFFF_FFFF, 32 back-to-back beats, prod_ready=1 -> prod_data=96'hFFFFFFFE_FFFFFFFF_00000001; prod_valid is high exactly once, 33 cycles after the first beat.
- in1=3, in2=5 (beats: 3,0,3, then 29 zeros) -> prod_data=96'h0000000F; pp_idx steps 0..31 and wraps to 0.
- Same as the previous scenario with pp_valid dropped every other cycle -> identical result 96'hF, with prod_valid at cycle 64.
- prod_ready held 0 for 5 cycles in DONE -> prod_valid and prod_data stable, pp_ready=0, and pp_valid=1 beats are not accepted; on release, the product is consumed and the block returns to IDLE one cycle later.
- Reset asserted after 10 beats of the all-ones case -> next cycle prod_valid=0, pp_idx=0, busy=0; a fresh in1=3, in2=5 sequence then yields 96'hF.
- Reset asserted in DONE with prod_ready=1 simultaneously -> no consume counted, prod_valid=0 next cycle, prod_data=0.
